// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
package memory_port_arbiter_pkg;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b01,
    CORE_LOCK = 2'b10
  } ArbiterState_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_CORE,
    GRANT_EXT
  } ArbiterGrant_t;

  localparam int STARVE_COUNT_WIDTH = 4;

  function automatic logic isCoreRead(MemoryMode_t mode);
    return (mode == LOAD) || (mode == STORE_PRELOAD);
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// External word-access port: request/accept handshake plus one-cycle response.
interface memory_port_arbiter_if;
  logic        extValid;
  logic        extWrite;
  logic [31:0] extAddress;
  logic [31:0] extWriteData;
  logic        extReady;
  logic        extRespValid;
  logic        extRespError;
  logic [31:0] extReadData;

  modport slave (
    input  extValid, extWrite, extAddress, extWriteData,
    output extReady, extRespValid, extRespError, extReadData
  );

  modport master (
    output extValid, extWrite, extAddress, extWriteData,
    input  extReady, extRespValid, extRespError, extReadData
  );
endinterface

// File: rtl/memory_port_arbiter_starvation_counter.sv
// Saturating count of consecutive denied external cycles.
module arbiter_starvation_counter
  import memory_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  input  logic freeze,
  output logic atLimit
);

  localparam logic [STARVE_COUNT_WIDTH-1:0] LIMIT = STARVE_LIMIT[STARVE_COUNT_WIDTH-1:0];

  logic [STARVE_COUNT_WIDTH-1:0] starveCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCount <= '0;
    end else if (!freeze) begin
      if (clear) begin
        starveCount <= '0;
      end else if (increment && (starveCount != LIMIT)) begin
        starveCount <= starveCount + 1'b1;
      end
    end
  end

  assign atLimit = (starveCount == LIMIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the single-ported data memory between the core and an external port.
//  state     | meaning
//  IDLE      | normal arbitration, core wins unless the external port is starved
//  CORE_LOCK | preload granted; only the core's following STORE may touch memory
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT        = 4,
  parameter int MEM_WORD_ADDR_WIDTH = 30
) (
  input  logic                           clock,
  input  logic                           reset,
  input  MemoryMode_t                    coreMemoryMode,
  input  logic [31:0]                    coreAddress,
  input  logic [31:0]                    coreWriteData,
  input  logic [3:0]                     coreByteEnable,
  output logic                           coreStall,
  output logic                           coreReadValid,
  output logic [31:0]                    coreReadData,
  output logic                           arbiterError,
  memory_port_arbiter_if.slave           extPort,
  output logic                           memReadEnable,
  output logic                           memWriteEnable,
  output logic [MEM_WORD_ADDR_WIDTH-1:0] memAddress,
  output logic [3:0]                     memByteEnable,
  output logic [31:0]                    memWriteData,
  input  logic [31:0]                    memReadData
);

  ArbiterState_t state;
  ArbiterGrant_t grant;
  logic coreReq, extReq, atLimit, extMisaligned, lockViolation;
  logic coreDoRead, coreDoWrite, extDoAccess;
  logic extRespValidQ, extRespErrorQ, extRespReadQ;
  logic unusedAddrBits;

  // Requests are masked while reset is held so every output stays quiet.
  assign coreReq       = reset && (coreMemoryMode != NOP);
  assign extReq        = reset && extPort.extValid;
  assign extMisaligned = (extPort.extAddress[1:0] != 2'b00);
  assign lockViolation = (state == CORE_LOCK) && (coreMemoryMode != STORE);

  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      grant = GRANT_NONE;
    end else if (state == CORE_LOCK) begin
      grant = GRANT_CORE;
    end else if (extReq && (!coreReq || atLimit)) begin
      grant = GRANT_EXT;
    end else if (coreReq) begin
      grant = GRANT_CORE;
    end
  end

  assign coreDoRead  = (grant == GRANT_CORE) && (state == IDLE) && isCoreRead(coreMemoryMode);
  assign coreDoWrite = (grant == GRANT_CORE) && (coreMemoryMode == STORE);
  assign extDoAccess = (grant == GRANT_EXT) && !extMisaligned;

  assign coreStall        = coreReq && (grant != GRANT_CORE);
  assign extPort.extReady = (grant == GRANT_EXT);

  always_comb begin
    memReadEnable  = coreDoRead  || (extDoAccess && !extPort.extWrite);
    memWriteEnable = coreDoWrite || (extDoAccess &&  extPort.extWrite);
    memAddress     = '0;
    memByteEnable  = '0;
    memWriteData   = '0;
    if (coreDoRead || coreDoWrite) begin
      memAddress = coreAddress[MEM_WORD_ADDR_WIDTH+1:2];
      if (coreDoWrite) begin
        memByteEnable = coreByteEnable;
        memWriteData  = coreWriteData;
      end
    end else if (extDoAccess) begin
      memAddress = extPort.extAddress[MEM_WORD_ADDR_WIDTH+1:2];
      if (extPort.extWrite) begin
        memByteEnable = 4'b1111;
        memWriteData  = extPort.extWriteData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      arbiterError  <= 1'b0;
      coreReadValid <= 1'b0;
      extRespValidQ <= 1'b0;
      extRespErrorQ <= 1'b0;
      extRespReadQ  <= 1'b0;
    end else begin
      coreReadValid <= coreDoRead;
      extRespValidQ <= (grant == GRANT_EXT);
      extRespErrorQ <= (grant == GRANT_EXT) && extMisaligned;
      extRespReadQ  <= extDoAccess && !extPort.extWrite;
      case (state)
        IDLE: begin
          if ((grant == GRANT_CORE) && (coreMemoryMode == STORE_PRELOAD)) begin
            state <= CORE_LOCK;
          end
        end
        CORE_LOCK: begin
          if (lockViolation) begin
            arbiterError <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is steered by the owner tag registered alongside the strobe.
  assign coreReadData         = coreReadValid ? memReadData : 32'h0;
  assign extPort.extRespValid = extRespValidQ;
  assign extPort.extRespError = extRespErrorQ;
  assign extPort.extReadData  = extRespReadQ ? memReadData : 32'h0;

  arbiter_starvation_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) starveCounter (
    .clock    (clock),
    .reset    (reset),
    .clear    ((grant == GRANT_EXT) || !extReq),
    .increment(extReq && (grant != GRANT_EXT)),
    .freeze   (state == CORE_LOCK),
    .atLimit  (atLimit)
  );

  assign unusedAddrBits = ^coreAddress[1:0];

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench: reference arbitration model predicts grants and responses.
module tb_memory_port_arbiter;
  import memory_port_arbiter_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  MemoryMode_t coreMemoryMode;
  logic [31:0] coreAddress, coreWriteData, coreReadData;
  logic [3:0]  coreByteEnable;
  logic        coreStall, coreReadValid, arbiterError;
  logic        memReadEnable, memWriteEnable;
  logic [29:0] memAddress;
  logic [3:0]  memByteEnable;
  logic [31:0] memWriteData, memReadData;

  memory_port_arbiter_if extBus();

  memory_port_arbiter #(.STARVE_LIMIT(LIMIT), .MEM_WORD_ADDR_WIDTH(30)) dut (
    .clock(clock), .reset(reset),
    .coreMemoryMode(coreMemoryMode), .coreAddress(coreAddress),
    .coreWriteData(coreWriteData), .coreByteEnable(coreByteEnable),
    .coreStall(coreStall), .coreReadValid(coreReadValid),
    .coreReadData(coreReadData), .arbiterError(arbiterError),
    .extPort(extBus),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memAddress(memAddress), .memByteEnable(memByteEnable),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  logic [31:0] ram    [64];
  logic [31:0] refMem [64];

  always @(posedge clock) begin
    if (memReadEnable) memReadData <= ram[memAddress[5:0]];
    if (memWriteEnable) begin
      for (int l = 0; l < 4; l++)
        if (memByteEnable[l]) ram[memAddress[5:0]][8*l +: 8] <= memWriteData[8*l +: 8];
    end
  end

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  resp_t coreQ[$];
  resp_t extQ[$];
  bit    mLocked = 0;
  bit    mErr = 0;
  int    denied = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic doCycle(input MemoryMode_t m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic ev, input logic ew,
                         input logic [31:0] ea, input logic [31:0] ewd,
                         output bit cStalled, output bit eWon);
    bit cReq, cWin, eWin, cRd, cWr, mis, errNext;
    resp_t r;
    @(negedge clock);
    coreMemoryMode = m; coreAddress = a; coreWriteData = wd; coreByteEnable = be;
    extBus.extValid = ev; extBus.extWrite = ew; extBus.extAddress = ea; extBus.extWriteData = ewd;
    #2;
    cReq = (m != NOP); mis = (ea[1:0] != 2'b00);
    cWin = 0; eWin = 0; cRd = 0; cWr = 0; errNext = 0;
    if (mLocked) begin
      cWin = 1; mLocked = 0;
      if (m == STORE) cWr = 1; else errNext = 1;
    end else begin
      eWin = ev && (!cReq || denied == LIMIT);
      cWin = cReq && !eWin;
      if (ev && !eWin) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
      else denied = 0;
      cRd = cWin && (m == LOAD || m == STORE_PRELOAD);
      cWr = cWin && (m == STORE);
      if (cWin && m == STORE_PRELOAD) mLocked = 1;
    end
    check("coreStall", coreStall, cReq && !cWin);
    check("extReady", extBus.extReady, eWin);
    check("memReadEnable", memReadEnable, cRd || (eWin && !mis && !ew));
    check("memWriteEnable", memWriteEnable, cWr || (eWin && !mis && ew));
    check("arbiterError", arbiterError, mErr);
    if (cRd || cWr) check("memAddressCore", memAddress, a[31:2]);
    else if (eWin && !mis) check("memAddressExt", memAddress, ea[31:2]);
    if (cWr) check("memByteEnableCore", memByteEnable, be);
    if (eWin && !mis && ew) check("memByteEnableExt", memByteEnable, 4'hF);
    if (cRd) begin
      r.cyc = cyc; r.err = 0; r.data = refMem[a[7:2]]; coreQ.push_back(r);
    end
    if (cWr) begin
      for (int l = 0; l < 4; l++) if (be[l]) refMem[a[7:2]][8*l +: 8] = wd[8*l +: 8];
    end
    if (eWin) begin
      r.cyc = cyc; r.err = mis; r.data = 32'h0;
      if (!mis && ew) refMem[ea[7:2]] = ewd;
      else if (!mis) r.data = refMem[ea[7:2]];
      extQ.push_back(r);
    end
    mErr = mErr | errNext;
    cStalled = cReq && !cWin;
    eWon = eWin;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    resp_t r;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      while (coreQ.size() > 0 && coreQ[0].cyc + 1 < cyc) begin
        tests++; fails++; r = coreQ.pop_front();
        $display("FAIL coreRespMissing: got no pulse, expected data %h at cycle %0d", r.data, r.cyc + 1);
      end
      while (extQ.size() > 0 && extQ[0].cyc + 1 < cyc) begin
        tests++; fails++; r = extQ.pop_front();
        $display("FAIL extRespMissing: got no pulse, expected data %h at cycle %0d", r.data, r.cyc + 1);
      end
      if (coreReadValid) begin
        if (coreQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL coreRespUnexpected: got pulse data %h, expected none", coreReadData);
        end else begin
          r = coreQ.pop_front();
          check("coreReadData", coreReadData, r.data);
        end
      end
      if (extBus.extRespValid) begin
        if (extQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL extRespUnexpected: got pulse data %h, expected none", extBus.extReadData);
        end else begin
          r = extQ.pop_front();
          check("extRespError", extBus.extRespError, r.err);
          check("extReadData", extBus.extReadData, r.data);
        end
      end
    end
  end

  initial begin
    MemoryMode_t m;
    logic [31:0] a, wd, ea, ewd;
    logic [3:0]  be;
    logic        ev, ew;
    bit          cStall, eWon, eWait, needStore;
    int          r;

    for (int i = 0; i < 64; i++) begin
      ram[i]    = 32'h1000_0000 + i * 32'h0101;
      refMem[i] = 32'h1000_0000 + i * 32'h0101;
    end
    ram[4] = 32'hDEADBEEF; refMem[4] = 32'hDEADBEEF;
    coreMemoryMode = NOP; coreAddress = 0; coreWriteData = 0; coreByteEnable = 0;
    extBus.extValid = 0; extBus.extWrite = 0; extBus.extAddress = 0; extBus.extWriteData = 0;

    #2;
    check("rstCoreStall", coreStall, 0);
    check("rstExtReady", extBus.extReady, 0);
    check("rstCoreReadValid", coreReadValid, 0);
    check("rstExtRespValid", extBus.extRespValid, 0);
    check("rstArbiterError", arbiterError, 0);
    check("rstMemStrobes", {memReadEnable, memWriteEnable}, 0);
    @(negedge clock); #3 reset = 1'b1;

    // Directed: external read of word 4
    doCycle(NOP, 0, 0, 0, 1, 0, 32'h10, 0, cStall, eWon);
    doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    // Contention: core LOAD every cycle, external write held until accepted
    eWait = 1;
    for (int i = 0; i < 7; i++) begin
      doCycle(LOAD, 32'h20, 0, 0, eWait, 1, 32'h24, 32'h11223344, cStall, eWon);
      if (eWon) eWait = 0;
    end

    // Atomic RMW while the external port sits at its starvation limit
    for (int i = 0; i < LIMIT - 1; i++)
      doCycle(LOAD, 32'h40, 0, 0, 1, 0, 32'h50, 0, cStall, eWon);
    doCycle(STORE_PRELOAD, 32'h30, 0, 0, 1, 0, 32'h50, 0, cStall, eWon);
    doCycle(STORE, 32'h30, 32'h0000AB00, 4'b0010, 1, 0, 32'h50, 0, cStall, eWon);
    doCycle(NOP, 0, 0, 0, 1, 0, 32'h50, 0, cStall, eWon);
    doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    // Misaligned external write
    doCycle(NOP, 0, 0, 0, 1, 1, 32'h13, 32'hFFFFFFFF, cStall, eWon);
    doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    // Randomized traffic obeying the hold-while-stalled and RMW rules
    cStall = 0; eWait = 0; needStore = 0;
    m = NOP; a = 0; wd = 0; be = 0; ev = 0; ew = 0; ea = 0; ewd = 0;
    for (int i = 0; i < 500; i++) begin
      if (!cStall) begin
        if (needStore) begin
          m = STORE; wd = $urandom; be = 4'($urandom_range(0, 15)); needStore = 0;
        end else begin
          r = $urandom_range(0, 9);
          m = (r < 3) ? NOP : (r < 6) ? LOAD : (r < 8) ? STORE : STORE_PRELOAD;
          a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          wd = $urandom; be = 4'($urandom_range(0, 15));
        end
      end
      if (!eWait) begin
        ev = ($urandom_range(0, 2) != 0); ew = 1'($urandom_range(0, 1));
        ea = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) ea[1:0] = 2'($urandom_range(1, 3));
        ewd = $urandom;
      end
      doCycle(m, a, wd, be, ev, ew, ea, ewd, cStall, eWon);
      eWait = ev && !eWon;
      if (!cStall && m == STORE_PRELOAD) needStore = 1;
    end
    for (int i = 0; i < 20 && (needStore || eWait || cStall); i++) begin
      if (needStore && !cStall) begin m = STORE; needStore = 0; end
      else if (!cStall) m = NOP;
      doCycle(m, a, wd, be, eWait, ew, ea, ewd, cStall, eWon);
      eWait = eWait && !eWon;
    end
    for (int i = 0; i < 3; i++) doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    // Asynchronous reset between an external grant and its response
    doCycle(NOP, 0, 0, 0, 1, 0, 32'h10, 0, cStall, eWon);
    #1 reset = 1'b0;
    coreQ.delete(); extQ.delete(); mLocked = 0; mErr = 0; denied = 0;
    coreMemoryMode = LOAD;
    #1;
    check("inRstCoreStall", coreStall, 0);
    check("inRstExtReady", extBus.extReady, 0);
    check("inRstMemStrobes", {memReadEnable, memWriteEnable}, 0);
    @(posedge clock); #1;
    check("inRstExtRespValid", extBus.extRespValid, 0);
    check("inRstCoreReadValid", coreReadValid, 0);
    check("inRstArbiterError", arbiterError, 0);
    @(negedge clock);
    coreMemoryMode = NOP; extBus.extValid = 0;
    #3 reset = 1'b1;
    for (int i = 0; i < 2; i++) doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    // Starvation count restarts from zero after reset
    eWait = 1;
    for (int i = 0; i < 7; i++) begin
      doCycle(LOAD, 32'h08, 0, 0, eWait, 0, 32'h0C, 0, cStall, eWon);
      if (eWon) eWait = 0;
    end

    // Protocol violation: preload followed by a load
    doCycle(STORE_PRELOAD, 32'h60, 0, 0, 0, 0, 0, 0, cStall, eWon);
    doCycle(LOAD, 32'h64, 0, 0, 0, 0, 0, 0, cStall, eWon);
    for (int i = 0; i < 3; i++) doCycle(LOAD, 32'h68, 0, 0, 0, 0, 0, 0, cStall, eWon);
    for (int i = 0; i < 3; i++) doCycle(NOP, 0, 0, 0, 0, 0, 0, 0, cStall, eWon);

    check("coreQueueDrained", coreQ.size(), 0);
    check("extQueueDrained", extQ.size(), 0);
    for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), ram[i], refMem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single-ported, synchronous-read data memory between two requesters: the core's MemoryController path and an external word-access port (debug/DMA loader).
- Core has priority by default. A starvation counter guarantees the external port is eventually served.
- The STORE_PRELOAD→STORE read-modify-write pair is atomic.
- Drives a stall line consumed by the control FSM, which holds its state while stalled.

Parameters:
- STARVE_LIMIT, 4: consecutive denied external cycles before the external port is forced a grant; legal range 1..15.
- MEM_WORD_ADDR_WIDTH, 30: width of the memory word address.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- coreMemoryMode  in  MemoryMode_t  NOP/LOAD/STORE_PRELOAD/STORE from the control FSM.
- coreAddress  in  32  byte address; bits [1:0] ignored here.
- coreWriteData  in  32  merged store word.
- coreByteEnable  in  4  byte lanes for STORE.
- coreStall  out  1  core requested but not granted this cycle.
- coreReadValid  out  1  coreReadData valid (one cycle after a granted LOAD/STORE_PRELOAD).
- coreReadData  out  32  memory read word for the core.
- arbiterError  out  1  sticky protocol-violation flag, feeds the control FSM halt logic.
- extValid  in  1  external request.
- extWrite  in  1  1 = write, 0 = read.
- extAddress  in  32  byte address; must be word aligned.
- extWriteData  in  32  external write word (all 4 lanes).
- extReady  out  1  external request accepted this cycle.
- extRespValid  out  1  one-cycle response pulse; no backpressure.
- extRespError  out  1  misaligned request, qualified by extRespValid.
- extReadData  out  32  read word; 0 for writes and errors.
- memReadEnable  out  1  synchronous read strobe.
- memWriteEnable  out  1  write strobe.
- memAddress  out  MEM_WORD_ADDR_WIDTH  word address.
- memByteEnable  out  4  write lanes.
- memWriteData  out  32  write word.
- memReadData  in  32  valid one cycle after memReadEnable.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, starveCount=0, arbiterError=0.
  - All registered outputs 0; mem strobes 0.
  - Any in-flight response is discarded and not re-issued after reset release.
- Request definitions: coreReq = coreMemoryMode!=NOP; extReq = extValid.
- States are IDLE and CORE_LOCK.
- Grant, evaluated combinationally each cycle:
  - CORE_LOCK: core always granted. extReady=0 and starveCount frozen.
  - IDLE, only one requester: that requester is granted.
  - IDLE, both requesting: external granted iff starveCount==STARVE_LIMIT, else core.
  - Neither requesting: no grant, memory strobes 0.
- starveCount:
  - Increments (saturating at STARVE_LIMIT) when extReq is denied.
  - Clears to 0 when external is granted or extReq=0.
- Outputs:
  - coreStall = coreReq & ~coreGranted.
  - extReady = extGranted.
- Memory drive:
  - Core LOAD/STORE_PRELOAD: memReadEnable=1, address=coreAddress[31:2].
  - Core STORE: memWriteEnable=1, memByteEnable=coreByteEnable.
  - Ext read: memReadEnable=1. Ext write: memWriteEnable=1, memByteEnable=4'b1111.
- Responses (registered owner tag; memReadData steered next cycle):
  - coreReadValid pulses 1 cycle after a granted core read.
  - extRespValid pulses 1 cycle after any accepted ext request.
  - Misaligned ext request (extAddress[1:0]!=0): accepted, no memory strobe, response has extRespError=1 and extReadData=0.
- CORE_LOCK entry and exit:
  - Entered on a granted STORE_PRELOAD.
  - Left on the next cycle's STORE → IDLE.
  - If the core presents anything but STORE while in CORE_LOCK: arbiterError←1, that access is not performed, state→IDLE.
- STORE_PRELOAD while in CORE_LOCK is also an error.
- A response pulse and a new grant in the same cycle are legal (back-to-back throughput of 1 access/cycle).
- Stalls:
  - The core holds its mode, address and data stable while coreStall=1.
  - The external side holds its request until extReady=1.

Decomposition:
- JZJCoreFTypes gains:
  - ArbiterState_t {IDLE, CORE_LOCK}, one-hot.
  - ArbiterGrant_t {GRANT_NONE, GRANT_CORE, GRANT_EXT}.
- MemoryMode_t is reused unchanged.
- One sub-module, arbiter_starvation_counter: saturating counter with clear/increment/freeze inputs and an atLimit output, parameterised by STARVE_LIMIT.

Test Plan:
- Ext read only: extValid=1, extAddress=0x10, mem word 4 = 0xDEADBEEF → extReady same cycle; next cycle extRespValid=1, extReadData=0xDEADBEEF, extRespError=0.
- Contention with STARVE_LIMIT=4: core LOAD every cycle, extValid held → coreStall=0 for 4 cycles; cycle 5 extReady=1 and coreStall=1; cycle 6 core granted and starveCount=0.
- Atomic RMW: core STORE_PRELOAD, then STORE (byteEnable 4'b0010, data 0x0000AB00) with extValid=1 and starveCount at limit → extReady=0 both cycles; memory word updated only in lane 1; ext granted on the cycle after.
- Protocol error: STORE_PRELOAD then LOAD → no memory strobe in the second cycle, arbiterError=1 and sticky, state IDLE.
- Misaligned ext write to 0x13 → extReady=1, memWriteEnable=0; next cycle extRespValid=1, extRespError=1, memory unchanged.
- Async reset asserted mid ext-read (between grant and response) → extRespValid never pulses; all outputs 0 during reset; starveCount=0 after release.
